// File: rtl/fpu_pkg.sv
// Shared FPU definitions used by the operand entry path and the result serializer.
package fpu_pkg;

    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd4,
        OP_CMP  = 3'd5,
        OP_CVT  = 3'd6,
        OP_NOP  = 3'd7
    } fpu_op_t;

endpackage

// File: rtl/fpu_result_serializer.sv
// Captures one FPU result word and streams it out as index-tagged byte slices
// over a valid/ready handshake, with back-to-back capture on the last slice.
module fpu_result_serializer #(
    parameter int DATA_W    = fpu_pkg::DATA_W,
    parameter int BYTE_W    = fpu_pkg::BYTE_W,
    parameter int IDX_W     = fpu_pkg::IDX_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res,
    input  logic              byte_ready,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              busy,
    output logic              done,
    output logic              ovf
);
    import fpu_pkg::*;

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(NBYTES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(NBYTES - 1);

    function automatic logic [BYTE_W-1:0] slice_of(input logic [DATA_W-1:0] w,
                                                   input logic [IDX_W-1:0]  i);
        return w[BYTE_W*i +: BYTE_W];
    endfunction

    state_t              state_reg;
    logic [DATA_W-1:0]   shadow_reg;
    logic [IDX_W-1:0]    idx_next;
    logic                xfer;
    logic                last_xfer;

    assign xfer      = byte_valid & byte_ready;
    assign last_xfer = xfer && (byte_idx == LAST_IDX);
    assign idx_next  = MSB_FIRST ? byte_idx - 1'b1 : byte_idx + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            byte_out   <= '0;
            byte_idx   <= '0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else if (clr) begin
            // shadow is deliberately kept so the aborted word can still be inspected
            state_reg  <= IDLE;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (res_valid) begin
                        shadow_reg <= res;
                        byte_idx   <= FIRST_IDX;
                        byte_out   <= slice_of(res, FIRST_IDX);
                        byte_valid <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        done <= 1'b1;
                        if (res_valid) begin
                            // back-to-back word: no idle bubble between words
                            shadow_reg <= res;
                            byte_idx   <= FIRST_IDX;
                            byte_out   <= slice_of(res, FIRST_IDX);
                        end else begin
                            byte_valid <= 1'b0;
                            busy       <= 1'b0;
                            state_reg  <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            byte_idx <= idx_next;
                            byte_out <= slice_of(shadow_reg, idx_next);
                        end
                        if (res_valid) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    byte_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_result_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share stimulus;
// a negedge monitor pops expected slices per instance on every transfer.
module tb_fpu_result_serializer;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res = '0;
    logic        byte_ready = 1'b0;

    logic       bv [2];
    logic [7:0] bo [2];
    logic [2:0] bi [2];
    logic       bz [2];
    logic       dn [2];
    logic       ov [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_result_serializer #(.DATA_W(32), .BYTE_W(8), .IDX_W(3), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstn(rstn), .clr(clr), .res_valid(res_valid), .res(res),
        .byte_ready(byte_ready), .byte_valid(bv[0]), .byte_out(bo[0]),
        .byte_idx(bi[0]), .busy(bz[0]), .done(dn[0]), .ovf(ov[0])
    );

    fpu_result_serializer #(.DATA_W(32), .BYTE_W(8), .IDX_W(3), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rstn(rstn), .clr(clr), .res_valid(res_valid), .res(res),
        .byte_ready(byte_ready), .byte_valid(bv[1]), .byte_out(bo[1]),
        .byte_idx(bi[1]), .busy(bz[1]), .done(dn[1]), .ovf(ov[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, req);
        end
    endtask

    // Expected slices of a word for both send orders; n limits how many are sent.
    task automatic push_word(input logic [31:0] w, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = 3'(3 - k);
            e.data = w[8*(3-k) +: 8];
            e.last = (k == 3);
            q0.push_back(e);
            e.idx  = 3'(k);
            e.data = w[8*k +: 8];
            q1.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int expect_cycles);
        int n;
        n = 0;
        while ((bz[0] || bz[1]) && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_cycles"}, 0, n, expect_cycles);
    endtask

    task automatic check_all(input string name, input logic v, input logic b,
                             input logic d, input logic o);
        for (int i = 0; i < 2; i++) begin
            chk({name, "_valid"}, i, 32'(bv[i]), 32'(v));
            chk({name, "_busy"},  i, 32'(bz[i]), 32'(b));
            chk({name, "_done"},  i, 32'(dn[i]), 32'(d));
            chk({name, "_ovf"},   i, 32'(ov[i]), 32'(o));
        end
    endtask

    task automatic strobe(input logic [31:0] w, input int n);
        push_word(w, n);
        res = w;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    // Monitor: done follows a last-slice transfer, stalls hold data, transfers pop.
    initial begin
        logic       pend_done [2];
        logic       held [2];
        logic [7:0] hold_b [2];
        logic [2:0] hold_i [2];
        exp_t       e;
        for (int i = 0; i < 2; i++) begin
            pend_done[i] = 1'b0;
            held[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (pend_done[d] || dn[d])
                    chk("done_pulse", d, 32'(dn[d]), 32'(pend_done[d]));
                pend_done[d] = 1'b0;
                if (held[d] && bv[d]) begin
                    chk("stall_byte", d, 32'(bo[d]), 32'(hold_b[d]));
                    chk("stall_idx",  d, 32'(bi[d]), 32'(hold_i[d]));
                end
                held[d] = 1'b0;
                if (bv[d] && !byte_ready && rstn) begin
                    held[d] = 1'b1;
                    hold_b[d] = bo[d];
                    hold_i[d] = bi[d];
                end
                if (bv[d] && byte_ready && rstn && !clr) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("unexpected_slice", d, {21'd0, bi[d], bo[d]}, 32'hFFFF_FFFF);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk("slice_idx",  d, 32'(bi[d]), 32'(e.idx));
                        chk("slice_byte", d, 32'(bo[d]), 32'(e.data));
                        pend_done[d] = e.last;
                    end
                end
            end
        end
    end

    initial begin
        // reset state
        rstn = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("reset_byte", i, 32'(bo[i]), 32'h0);
            chk("reset_idx",  i, 32'(bi[i]), 32'h0);
        end
        rstn = 1'b1;
        tick();

        // basic word, ready held high: 4 slices on 4 consecutive cycles
        byte_ready = 1'b1;
        strobe(32'h40ADF06F, 4);
        wait_idle("t1", 4);
        check_all("t1_end", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // ready toggling with stalls
        begin
            logic [6:0] pat;
            pat = 7'b1101001;  // bit 0 first: 1,0,0,1,0,1,1
            byte_ready = 1'b0;
            strobe(32'h40ADF06F, 4);
            for (int k = 0; k < 7; k++) begin
                byte_ready = pat[k];
                tick();
            end
            byte_ready = 1'b0;
            check_all("t3_end", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();

        // strobe mid-transfer is dropped and sets ovf
        byte_ready = 1'b1;
        strobe(32'h40ADF06F, 4);
        tick();
        res = 32'h3A378000;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        wait_idle("t4a", 2);
        check_all("t4a_end", 1'b0, 1'b0, 1'b1, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("t4a_clr", 1'b0, 1'b0, 1'b0, 1'b0);

        // strobe on last-transfer cycle is accepted back-to-back
        strobe(32'h40ADF06F, 4);
        tick();
        tick();
        tick();
        strobe(32'h3A378000, 4);
        check_all("t4b_b2b", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4b_first_idx", 0, 32'(bi[0]), 32'd3);
        chk("t4b_first_idx", 1, 32'(bi[1]), 32'd0);
        wait_idle("t4b", 4);
        check_all("t4b_end", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // clr after two slices, with a coincident res_valid that must be ignored
        strobe(32'h40ADF06F, 2);
        tick();
        tick();
        byte_ready = 1'b0;
        clr = 1'b1;
        res = 32'h3A378000;
        res_valid = 1'b1;
        tick();
        clr = 1'b0;
        res_valid = 1'b0;
        check_all("t5_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        byte_ready = 1'b1;
        strobe(32'h3A378000, 4);
        chk("t5_restart_idx", 0, 32'(bi[0]), 32'd3);
        wait_idle("t5", 4);
        tick();

        // asynchronous reset mid-transfer
        strobe(32'h40ADF06F, 1);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_all("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("t6_rst_byte", i, 32'(bo[i]), 32'h0);
            chk("t6_rst_idx",  i, 32'(bi[i]), 32'h0);
        end
        tick();
        rstn = 1'b1;
        tick();
        strobe(32'h40ADF06F, 4);
        wait_idle("t6", 4);
        tick();
        tick();

        chk("queue_empty", 0, 32'(q0.size()), 32'd0);
        chk("queue_empty", 1, 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
